h2f_serial_tx: RTL

//  HPS-to-FPGA transfer path: Avalon-MM slave on the HPS lightweight bridge. HPS writes data words into a FIFO.
//  The block drains the FIFO and serializes each word onto one fabric line, signal_tx, LSB first with a UART-style frame.

---
 rtl/h2f_serial_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/h2f_serial_tx.sv
// Avalon-MM fed FIFO drained onto a UART-style LSB-first serial line; DATA write to start bit is 2 cycles, readdata 1 cycle.
// No waitrequest: writes to a full FIFO are dropped and flagged in the sticky ovf bit.
module h2f_serial_tx #(
    parameter int DATA_W      = 32,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_DEFAULT = 49
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [1:0]        avs_address,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic              avs_read,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              signal_tx,
    output logic              tx_busy,
    output logic              irq
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int IW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [LW-1:0]     level;
    logic              ovf, en, ie;
    logic [15:0]       div, timer;
    logic [DATA_W-1:0] shift;
    logic [IW-1:0]     idx;
    logic              fifo_empty, fifo_full;
    logic              wr_data, push_ok, push_drop, pop, bit_end;
    logic [31:0]       rd_mux;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LW'(FIFO_DEPTH));
    assign wr_data    = avs_write && (avs_address == 2'd0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok    = wr_data && (!fifo_full || pop);
    assign push_drop  = wr_data && !push_ok;
    assign bit_end    = (timer == 16'd0);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (en && !fifo_empty) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                if (bit_end) state_n = DATA;
            end
            DATA: begin
                if (bit_end && idx == IW'(DATA_W - 1)) state_n = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (en && !fifo_empty) begin
                        pop     = 1'b1;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
            timer <= 16'd0;
            shift <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            // Timer reloads from the live DIV at every bit boundary.
            if (pop) begin
                timer <= div;
            end else if (state != IDLE) begin
                timer <= bit_end ? div : timer - 16'd1;
            end
            if (pop) begin
                shift <= mem[rd_ptr];
            end else if (state == DATA && bit_end) begin
                shift <= shift >> 1;
            end
            if (state == START && bit_end) begin
                idx <= '0;
            end else if (state == DATA && bit_end) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push_ok) mem[wr_ptr] <= avs_writedata;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
            en     <= 1'b0;
            ie     <= 1'b0;
            div    <= 16'(DIV_DEFAULT);
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push_ok) - LW'(pop);
            if (push_drop) begin
                ovf <= 1'b1;
            end else if (avs_write && avs_address == 2'd1 && avs_writedata[3]) begin
                ovf <= 1'b0;
            end
            if (avs_write && avs_address == 2'd2) begin
                en <= avs_writedata[0];
                ie <= avs_writedata[1];
            end
            if (avs_write && avs_address == 2'd3) begin
                div <= 16'(avs_writedata);
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (avs_address)
            2'd1:    rd_mux = {16'd0, 8'(level), 4'd0, ovf, fifo_full, fifo_empty, tx_busy};
            2'd2:    rd_mux = {30'd0, ie, en};
            2'd3:    rd_mux = {16'd0, div};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered from pre-write state, so a same-cycle write is not visible.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= DATA_W'(rd_mux);
        end
    end

    assign tx_busy   = (state != IDLE);
    assign signal_tx = (state == START) ? 1'b0 :
                       (state == DATA)  ? shift[0] : 1'b1;
    assign irq       = ie && fifo_empty && !tx_busy;

endmodule
